id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline stage directly upstream of the ALU in the 5-stage MIPS pipeline.
- Registers decoded ID fields once per cycle and generates the 3-bit ALU control from ALUOp/funct.
- Drives the ALU operands through EX/MEM and MEM/WB forwarding muxes.
- Detects load-use hazards, inserts bubbles, and honours downstream stall and branch flush.

Parameters:
- SIZE, 9, MSB index of the datapath; data width is SIZE+1 (10 bits by default, matching the ALU).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  downstream stall; hold stage contents
- flush  in  1  branch/jump flush; next stage content is a bubble
- id_valid  in  1  ID holds a real instruction
- id_alu_op  in  2  00 add (lw/sw), 01 sub (beq), 10 R-type via funct, 11 or (ori)
- id_funct  in  6  R-type funct field
- id_rs_data, id_rt_data  in  SIZE+1  register-file read data
- id_imm  in  SIZE+1  pre-extended immediate
- id_rs, id_rt, id_rd  in  5  register numbers
- id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  decoded control bits
- exmem_reg_write  in  1; exmem_rd  in  5; exmem_result  in  SIZE+1  EX/MEM forwarding source
- memwb_reg_write  in  1; memwb_rd  in  5; memwb_result  in  SIZE+1  MEM/WB forwarding source
- alu_ctl  out  3  ALU control, registered
- alu_in1, alu_in2  out  SIZE+1  forwarded ALU operands, combinational from stage registers
- ex_store_data  out  SIZE+1  forwarded rt value for sw
- ex_dest  out  5  destination register, registered
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal  out  1 each  registered
- load_use_stall  out  1  combinational; ID/IF must hold while it is high

Behaviour:
- Clock and reset: clk is the single clock; reset is synchronous and active-high.
- Reset: all registered outputs and stage registers are 0; alu_ctl=000; load_use_stall=0.
- Latency: one cycle from ID inputs to registered outputs.
- Per-edge priority: reset > flush > stall > load_use bubble > normal load.
- Flush: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal go to 0; other fields are don't-care.
- Stall: all fields hold, except the rs/rt data registers, which reload with their currently forwarded values. A producer retiring during the stall is therefore not lost.
- Load-use: load_use_stall = ex_valid & ex_mem_read & (ex_dest != 0) & id_valid & (ex_dest == id_rs | ex_dest == id_rt).
  - When load_use_stall is high and there is no stall/flush, the next edge loads a bubble (same fields as flush).
  - load_use_stall is forced to 0 while flush is high.
- Normal load:
  - All id_* fields are captured and ex_valid = id_valid.
  - ex_dest = id_reg_dst ? id_rd : id_rt.
  - Control bits are gated by id_valid.
- ALU control encoding: AND 000, OR 001, ADD 010, NOR 100, SUB 110, SLT 111.
- ALU control decode from alu_op:
  - 00 → ADD; 01 → SUB; 11 → OR.
  - 10 → decode funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT.
  - Any other funct → ADD, and ex_illegal = id_valid.
- Forwarding, for each of rs and rt:
  - Use exmem_result if exmem_reg_write & exmem_rd == reg & reg != 0.
  - Else use memwb_result if memwb_reg_write & memwb_rd == reg & reg != 0.
  - Else use the stored register data.
  - EX/MEM always wins over MEM/WB.
- Operand outputs:
  - alu_in1 = fwd(rs).
  - alu_in2 = ex_alu_src ? ex_imm : fwd(rt).
  - ex_store_data = fwd(rt), regardless of alu_src.
- Width: no arithmetic in this block; all data paths are SIZE+1 bits with no truncation.
- Reset asserted mid-stall or mid-bubble clears everything on that edge; the first edge after reset deasserts behaves as a normal load.

Decomposition:
- Shared package/include: ALU control encodings, ALUOp encodings, funct constants. The ALU and its bench use the same definitions.
- One natural sub-module, fwd_mux (one instance per operand): inputs are register number, stored data and both forwarding sources; output is the selected value.
- The ALU control decode stays inline as a case statement.

Test Plan:
- Reset: hold reset 2 cycles with id_valid=1 → all outputs 0, alu_ctl=000; first post-reset edge loads the ID fields.
- R-type decode: alu_op=10, funct=100010, rs_data=512, rt_data=256 → next cycle alu_ctl=110, alu_in1=512, alu_in2=256. Then funct=111111 → alu_ctl=010, ex_illegal=1.
- Forwarding priority: ex rs=5, exmem_rd=5 (768), memwb_rd=5 (128), both writing → alu_in1=768. Drop exmem_reg_write → 128. rs=0 with both sources matching rd=0 → stored data.
- Load-use: EX holds lw with dest=8; ID uses rs=8 → load_use_stall=1 and next cycle ex_valid=0, ex_mem_read=0. Following cycle loads the dependent instruction.
- Stall/flush: stall=1 for 3 cycles while memwb writes rt=9 with 300 → ex_store_data=300 after stall release. flush together with stall → bubble (ex_valid=0).
- Immediate: alu_op=11, alu_src=1, imm=128, rs_data=768 → alu_ctl=001, alu_in1=768, alu_in2=128.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared MIPS ALU encodings: ALU control codes, ALUOp classes and R-type funct values.
// Also holds the ID/EX control bundle type.
package id_ex_stage_pkg;

   typedef enum logic [2:0] {
      ALU_AND = 3'b000,
      ALU_OR  = 3'b001,
      ALU_ADD = 3'b010,
      ALU_NOR = 3'b100,
      ALU_SUB = 3'b110,
      ALU_SLT = 3'b111
   } alu_ctl_e;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_RTYPE = 2'b10,
      ALUOP_OR    = 2'b11
   } alu_op_e;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_NOR = 6'b100111;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   typedef struct packed {
      logic valid;
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic mem_to_reg;
      logic illegal;
   } ex_ctl_t;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding select: EX/MEM result, else MEM/WB result, else stored register data.
module id_ex_stage_fwd_mux #(
   parameter int SIZE = 9
) (
   input  logic [4:0]      rs,
   input  logic [SIZE:0]   stored,
   input  logic            exmem_reg_write,
   input  logic [4:0]      exmem_rd,
   input  logic [SIZE:0]   exmem_result,
   input  logic            memwb_reg_write,
   input  logic [4:0]      memwb_rd,
   input  logic [SIZE:0]   memwb_result,
   output logic [SIZE:0]   value
);

   logic hit_exmem;
   logic hit_memwb;

   // Register 0 is hardwired, so it never takes a forwarded value.
   assign hit_exmem = exmem_reg_write && (exmem_rd == rs) && (rs != 5'd0);
   assign hit_memwb = memwb_reg_write && (memwb_rd == rs) && (rs != 5'd0);

   always_comb begin
      value = stored;
      if (hit_exmem)
         value = exmem_result;
      else if (hit_memwb)
         value = memwb_result;
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU control decode, operand forwarding and load-use bubble insertion.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int SIZE = 9
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            flush,
   input  logic            id_valid,
   input  logic [1:0]      id_alu_op,
   input  logic [5:0]      id_funct,
   input  logic [SIZE:0]   id_rs_data,
   input  logic [SIZE:0]   id_rt_data,
   input  logic [SIZE:0]   id_imm,
   input  logic [4:0]      id_rs,
   input  logic [4:0]      id_rt,
   input  logic [4:0]      id_rd,
   input  logic            id_alu_src,
   input  logic            id_reg_dst,
   input  logic            id_reg_write,
   input  logic            id_mem_read,
   input  logic            id_mem_write,
   input  logic            id_mem_to_reg,
   input  logic            exmem_reg_write,
   input  logic [4:0]      exmem_rd,
   input  logic [SIZE:0]   exmem_result,
   input  logic            memwb_reg_write,
   input  logic [4:0]      memwb_rd,
   input  logic [SIZE:0]   memwb_result,
   output logic [2:0]      alu_ctl,
   output logic [SIZE:0]   alu_in1,
   output logic [SIZE:0]   alu_in2,
   output logic [SIZE:0]   ex_store_data,
   output logic [4:0]      ex_dest,
   output logic            ex_valid,
   output logic            ex_reg_write,
   output logic            ex_mem_read,
   output logic            ex_mem_write,
   output logic            ex_mem_to_reg,
   output logic            ex_illegal,
   output logic            load_use_stall
);

   ex_ctl_t       ctl_q;
   alu_ctl_e      alu_ctl_q;
   logic [4:0]    dest_q;
   logic [4:0]    rs_q;
   logic [4:0]    rt_q;
   logic [SIZE:0] rs_data_q;
   logic [SIZE:0] rt_data_q;
   logic [SIZE:0] imm_q;
   logic          alu_src_q;

   alu_ctl_e      dec_ctl;
   logic          dec_illegal;
   logic [SIZE:0] fwd_rs;
   logic [SIZE:0] fwd_rt;

   always_comb begin
      dec_ctl     = ALU_ADD;
      dec_illegal = 1'b0;
      case (id_alu_op)
         ALUOP_ADD: dec_ctl = ALU_ADD;
         ALUOP_SUB: dec_ctl = ALU_SUB;
         ALUOP_OR:  dec_ctl = ALU_OR;
         default: begin
            case (id_funct)
               FUNCT_ADD: dec_ctl = ALU_ADD;
               FUNCT_SUB: dec_ctl = ALU_SUB;
               FUNCT_AND: dec_ctl = ALU_AND;
               FUNCT_OR:  dec_ctl = ALU_OR;
               FUNCT_NOR: dec_ctl = ALU_NOR;
               FUNCT_SLT: dec_ctl = ALU_SLT;
               default: begin
                  dec_ctl     = ALU_ADD;
                  dec_illegal = 1'b1;
               end
            endcase
         end
      endcase
   end

   id_ex_stage_fwd_mux #(.SIZE(SIZE)) u_fwd_rs (
      .rs              (rs_q),
      .stored          (rs_data_q),
      .exmem_reg_write (exmem_reg_write),
      .exmem_rd        (exmem_rd),
      .exmem_result    (exmem_result),
      .memwb_reg_write (memwb_reg_write),
      .memwb_rd        (memwb_rd),
      .memwb_result    (memwb_result),
      .value           (fwd_rs)
   );

   id_ex_stage_fwd_mux #(.SIZE(SIZE)) u_fwd_rt (
      .rs              (rt_q),
      .stored          (rt_data_q),
      .exmem_reg_write (exmem_reg_write),
      .exmem_rd        (exmem_rd),
      .exmem_result    (exmem_result),
      .memwb_reg_write (memwb_reg_write),
      .memwb_rd        (memwb_rd),
      .memwb_result    (memwb_result),
      .value           (fwd_rt)
   );

   assign load_use_stall = !flush && ctl_q.valid && ctl_q.mem_read && (dest_q != 5'd0) &&
                           id_valid && ((dest_q == id_rs) || (dest_q == id_rt));

   always_ff @(posedge clk) begin
      if (reset) begin
         ctl_q     <= '0;
         alu_ctl_q <= ALU_AND;
         dest_q    <= '0;
         rs_q      <= '0;
         rt_q      <= '0;
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_q     <= '0;
         alu_src_q <= 1'b0;
      end else if (flush) begin
         ctl_q <= '0;
      end else if (stall) begin
         // Capture forwarded operands so a producer retiring during the stall is kept.
         rs_data_q <= fwd_rs;
         rt_data_q <= fwd_rt;
      end else if (load_use_stall) begin
         ctl_q <= '0;
      end else begin
         ctl_q.valid      <= id_valid;
         ctl_q.reg_write  <= id_valid && id_reg_write;
         ctl_q.mem_read   <= id_valid && id_mem_read;
         ctl_q.mem_write  <= id_valid && id_mem_write;
         ctl_q.mem_to_reg <= id_valid && id_mem_to_reg;
         ctl_q.illegal    <= id_valid && dec_illegal;
         alu_ctl_q        <= dec_ctl;
         dest_q           <= id_reg_dst ? id_rd : id_rt;
         rs_q             <= id_rs;
         rt_q             <= id_rt;
         rs_data_q        <= id_rs_data;
         rt_data_q        <= id_rt_data;
         imm_q            <= id_imm;
         alu_src_q        <= id_alu_src;
      end
   end

   assign alu_ctl       = alu_ctl_q;
   assign ex_dest       = dest_q;
   assign ex_valid      = ctl_q.valid;
   assign ex_reg_write  = ctl_q.reg_write;
   assign ex_mem_read   = ctl_q.mem_read;
   assign ex_mem_write  = ctl_q.mem_write;
   assign ex_mem_to_reg = ctl_q.mem_to_reg;
   assign ex_illegal    = ctl_q.illegal;
   assign alu_in1       = fwd_rs;
   assign alu_in2       = alu_src_q ? imm_q : fwd_rt;
   assign ex_store_data = fwd_rt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode, forwarding, load-use bubble, stall, flush and reset.
module tb_id_ex_stage;

   logic       clk = 1'b0;
   logic       reset, stall, flush, id_valid;
   logic [1:0] id_alu_op;
   logic [5:0] id_funct;
   logic [9:0] id_rs_data, id_rt_data, id_imm;
   logic [4:0] id_rs, id_rt, id_rd;
   logic       id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
   logic       exmem_reg_write, memwb_reg_write;
   logic [4:0] exmem_rd, memwb_rd;
   logic [9:0] exmem_result, memwb_result;
   logic [2:0] alu_ctl;
   logic [9:0] alu_in1, alu_in2, ex_store_data;
   logic [4:0] ex_dest;
   logic       ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal;
   logic       load_use_stall;

   int total = 0;
   int bad   = 0;

   id_ex_stage #(.SIZE(9)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
      .id_alu_op(id_alu_op), .id_funct(id_funct), .id_rs_data(id_rs_data),
      .id_rt_data(id_rt_data), .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
      .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
      .alu_ctl(alu_ctl), .alu_in1(alu_in1), .alu_in2(alu_in2), .ex_store_data(ex_store_data),
      .ex_dest(ex_dest), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
      .ex_illegal(ex_illegal), .load_use_stall(load_use_stall)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      id_valid = 1'b1; id_alu_op = 2'b10; id_funct = 6'b100010;
      id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3;
      id_rs_data = 10'd512; id_rt_data = 10'd256; id_imm = 10'd0;
      id_alu_src = 1'b0; id_reg_dst = 1'b1; id_reg_write = 1'b1;
      id_mem_read = 1'b0; id_mem_write = 1'b0; id_mem_to_reg = 1'b0;
      exmem_reg_write = 1'b0; exmem_rd = 5'd0; exmem_result = 10'd0;
      memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_result = 10'd0;

      // Reset held two cycles with a valid instruction presented
      tick(); tick();
      check("rst_alu_ctl", alu_ctl, 0);
      check("rst_valid", ex_valid, 0);
      check("rst_reg_write", ex_reg_write, 0);
      check("rst_dest", ex_dest, 0);
      check("rst_in1", alu_in1, 0);
      check("rst_in2", alu_in2, 0);
      check("rst_store", ex_store_data, 0);
      check("rst_lus", load_use_stall, 0);

      // First post-reset edge: R-type SUB
      reset = 1'b0;
      tick();
      check("sub_alu_ctl", alu_ctl, 3'b110);
      check("sub_in1", alu_in1, 512);
      check("sub_in2", alu_in2, 256);
      check("sub_dest", ex_dest, 3);
      check("sub_valid", ex_valid, 1);
      check("sub_reg_write", ex_reg_write, 1);
      check("sub_illegal", ex_illegal, 0);

      // Unknown funct decodes as ADD and flags illegal
      id_funct = 6'b111111;
      tick();
      check("ill_alu_ctl", alu_ctl, 3'b010);
      check("ill_flag", ex_illegal, 1);

      // Forwarding priority on rs
      id_funct = 6'b100000; id_rs = 5'd5; id_rs_data = 10'd10;
      tick();
      check("fwd_none", alu_in1, 10);
      exmem_reg_write = 1'b1; exmem_rd = 5'd5; exmem_result = 10'd768;
      memwb_reg_write = 1'b1; memwb_rd = 5'd5; memwb_result = 10'd128;
      #1;
      check("fwd_exmem_wins", alu_in1, 768);
      exmem_reg_write = 1'b0;
      #1;
      check("fwd_memwb", alu_in1, 128);
      id_rs = 5'd0; id_rs_data = 10'd33;
      exmem_reg_write = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
      tick();
      check("fwd_r0_stored", alu_in1, 33);
      check("fwd_r0_rt_stored", alu_in2, 256);
      exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;

      // Load-use: lw r8 in EX, dependent add in ID
      id_alu_op = 2'b00; id_rs = 5'd1; id_rt = 5'd8; id_rs_data = 10'd100; id_imm = 10'd4;
      id_alu_src = 1'b1; id_reg_dst = 1'b0; id_mem_read = 1'b1; id_mem_to_reg = 1'b1;
      tick();
      check("lw_dest", ex_dest, 8);
      check("lw_mem_read", ex_mem_read, 1);
      check("lw_mem_to_reg", ex_mem_to_reg, 1);
      check("lw_in2_imm", alu_in2, 4);
      id_alu_op = 2'b10; id_funct = 6'b100000; id_rs = 5'd8; id_rt = 5'd2; id_rd = 5'd4;
      id_rs_data = 10'd0; id_alu_src = 1'b0; id_reg_dst = 1'b1;
      id_mem_read = 1'b0; id_mem_to_reg = 1'b0;
      #1;
      check("lu_stall_high", load_use_stall, 1);
      tick();
      check("lu_bubble_valid", ex_valid, 0);
      check("lu_bubble_mem_read", ex_mem_read, 0);
      check("lu_bubble_reg_write", ex_reg_write, 0);
      check("lu_stall_low", load_use_stall, 0);
      memwb_reg_write = 1'b1; memwb_rd = 5'd8; memwb_result = 10'd77;
      tick();
      check("lu_dep_valid", ex_valid, 1);
      check("lu_dep_dest", ex_dest, 4);
      check("lu_dep_in1", alu_in1, 77);
      memwb_reg_write = 1'b0;

      // Stall while MEM/WB retires rt=9 only on the first stalled edge
      id_rs = 5'd1; id_rt = 5'd9; id_rd = 5'd5; id_rs_data = 10'd1; id_rt_data = 10'd2;
      tick();
      check("pre_stall_store", ex_store_data, 2);
      stall = 1'b1; memwb_reg_write = 1'b1; memwb_rd = 5'd9; memwb_result = 10'd300;
      id_rd = 5'd6; id_rt_data = 10'd999;
      tick();
      memwb_reg_write = 1'b0;
      tick();
      check("stall_hold_dest", ex_dest, 5);
      tick();
      stall = 1'b0;
      #1;
      check("stall_store_kept", ex_store_data, 300);
      check("stall_hold_valid", ex_valid, 1);

      // Flush masks load-use and wins over stall
      id_alu_op = 2'b00; id_rs = 5'd1; id_rt = 5'd8; id_alu_src = 1'b1; id_reg_dst = 1'b0;
      id_mem_read = 1'b1; id_mem_to_reg = 1'b1;
      tick();
      id_alu_op = 2'b10; id_rs = 5'd8; id_rt = 5'd2; id_rd = 5'd4; id_alu_src = 1'b0;
      id_reg_dst = 1'b1; id_mem_read = 1'b0; id_mem_to_reg = 1'b0;
      flush = 1'b1; stall = 1'b1;
      #1;
      check("flush_masks_lus", load_use_stall, 0);
      tick();
      check("flush_valid", ex_valid, 0);
      check("flush_mem_read", ex_mem_read, 0);
      flush = 1'b0; stall = 1'b0;

      // ori-style immediate
      id_alu_op = 2'b11; id_alu_src = 1'b1; id_imm = 10'd128; id_rs = 5'd1; id_rt = 5'd2;
      id_rs_data = 10'd768; id_rt_data = 10'd256; id_reg_dst = 1'b0;
      tick();
      check("ori_alu_ctl", alu_ctl, 3'b001);
      check("ori_in1", alu_in1, 768);
      check("ori_in2", alu_in2, 128);
      check("ori_store", ex_store_data, 256);
      check("ori_dest", ex_dest, 2);

      // Control bits gated by id_valid
      id_valid = 1'b0; id_mem_write = 1'b1;
      tick();
      check("inv_valid", ex_valid, 0);
      check("inv_reg_write", ex_reg_write, 0);
      check("inv_mem_write", ex_mem_write, 0);

      // Reset during stall clears; next edge is a normal load
      id_valid = 1'b1; id_mem_write = 1'b0;
      tick();
      check("pre_rst_valid", ex_valid, 1);
      reset = 1'b1; stall = 1'b1;
      tick();
      check("midrst_alu_ctl", alu_ctl, 0);
      check("midrst_valid", ex_valid, 0);
      check("midrst_in1", alu_in1, 0);
      reset = 1'b0; stall = 1'b0;
      tick();
      check("postrst_alu_ctl", alu_ctl, 3'b001);
      check("postrst_valid", ex_valid, 1);
      check("postrst_in1", alu_in1, 768);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
